// File: rtl/uart_fifo_bridge_if.sv
// ============================================================================
// Module  : uart_fifo_bridge_if
// Purpose : Host-side signal bundle of the UART FIFO bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface uart_fifo_bridge_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              echo_en_i;
  logic              rd_en_i;
  logic              stat_req_i;
  logic              clr_err_i;
  logic [DATA_W-1:0] data_o;
  logic              rx_valid_o;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;
  logic              frame_err_o;
  logic              tx_busy_o;

  modport master (
    output echo_en_i, rd_en_i, stat_req_i, clr_err_i,
    input  data_o, rx_valid_o, full_o, empty_o, count_o,
    input  overflow_o, frame_err_o, tx_busy_o
  );

  modport slave (
    input  echo_en_i, rd_en_i, stat_req_i, clr_err_i,
    output data_o, rx_valid_o, full_o, empty_o, count_o,
    output overflow_o, frame_err_o, tx_busy_o
  );
endinterface

`default_nettype wire

// File: rtl/uart_fifo_bridge.sv
// ============================================================================
// Module  : uart_fifo_bridge
// Purpose : UART RX -> FIFO -> UART TX endpoint with host drain, echo and status.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module uart_fifo_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_serial,
  output logic                tx_serial,
  uart_fifo_bridge_if.slave   host
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CLK_W-1:0] BIT_END  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CLK_W-1:0] HALF_END = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] CH_EMPTY   = 8'h65;
  localparam logic [7:0] CH_FULL    = 8'h66;
  localparam logic [7:0] CH_NEITHER = 8'h6E;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // ---------------------------------------------------------------- state
  logic              rx_meta_q, rx_sync_q;
  rx_state_e         rx_state_q, rx_state_d;
  logic [CLK_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]  rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;

  tx_state_e         tx_state_q, tx_state_d;
  logic [CLK_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]  tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_serial_q, tx_serial_d;
  logic              stat_pend_q, stat_pend_d;

  logic              rx_push, rx_frame_bad;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              host_pop, echo_pop, pop, push_ok;

  // ---------------------------------------------------------------- RX
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;
    rx_frame_bad = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line mid start bit so short glitches are discarded.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_state_d   = RX_IDLE;
          rx_push      = rx_sync_q;
          rx_frame_bad = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_head  = fifo_empty ? '0 : mem_q[rd_ptr_q];

  assign host_pop = !host.echo_en_i && host.rd_en_i && !fifo_empty;
  assign pop      = host_pop || echo_pop;
  assign push_ok  = rx_push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    // A new error in the same cycle as a clear keeps the flag set.
    if (host.clr_err_i) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
    end
    if (rx_push && !push_ok) overflow_d  = 1'b1;
    if (rx_frame_bad)        frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------------------------------------------------------- TX
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    stat_pend_d = stat_pend_q || host.stat_req_i;
    echo_pop    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (stat_pend_q) begin
          stat_pend_d = 1'b0;
          tx_state_d  = TX_START;
          if (fifo_empty)     tx_shift_d = DATA_W'(CH_EMPTY);
          else if (fifo_full) tx_shift_d = DATA_W'(CH_FULL);
          else                tx_shift_d = DATA_W'(CH_NEITHER);
        end else if (host.echo_en_i && !fifo_empty) begin
          echo_pop   = 1'b1;
          tx_shift_d = fifo_head;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_END) begin
          tx_cnt_d = '0;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_END) tx_state_d = TX_IDLE;
        else                     tx_cnt_d   = tx_cnt_q + 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level follows the state being entered, so the output stays registered.
    case (tx_state_d)
      TX_START: tx_serial_d = 1'b0;
      TX_DATA:  tx_serial_d = tx_shift_d[0];
      default:  tx_serial_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_serial_q <= 1'b1;
      stat_pend_q <= 1'b0;
    end else begin
      rx_meta_q   <= rx_serial;
      rx_sync_q   <= rx_meta_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_serial_q <= tx_serial_d;
      stat_pend_q <= stat_pend_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign tx_serial        = tx_serial_q;
  assign host.data_o      = fifo_head;
  assign host.rx_valid_o  = rx_push;
  assign host.full_o      = fifo_full;
  assign host.empty_o     = fifo_empty;
  assign host.count_o     = count_q;
  assign host.overflow_o  = overflow_q;
  assign host.frame_err_o = frame_err_q;
  assign host.tx_busy_o   = (tx_state_q != TX_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_bridge.sv
// ============================================================================
// Module  : tb_uart_fifo_bridge
// Purpose : Directed self-checking bench for uart_fifo_bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_uart_fifo_bridge;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_line = 1'b1;
  logic tx_line;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int rv_cnt    = 0;

  uart_fifo_bridge_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) hif ();

  uart_fifo_bridge #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_serial (rx_line),
    .tx_serial (tx_line),
    .host      (hif.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && hif.rx_valid_o === 1'b1) rv_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_line = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < DW; i++) begin
      rx_line = b[i];
      wait_cyc(CPB);
    end
    rx_line = stop_bit;
    wait_cyc(CPB);
    rx_line = 1'b1;
    wait_cyc(8);
  endtask

  task automatic pulse_pop();
    hif.rd_en_i = 1'b1;
    @(negedge clk);
    hif.rd_en_i = 1'b0;
  endtask

  task automatic pulse_stat();
    hif.stat_req_i = 1'b1;
    @(negedge clk);
    hif.stat_req_i = 1'b0;
  endtask

  // Waits (bounded) for a start bit on tx_line and samples the frame mid-bit.
  task automatic capture(input string tag, output logic [7:0] b, output logic framing_ok);
    int   n = 0;
    logic timed_out;
    logic st, sp;
    b = '0;
    framing_ok = 1'b0;
    while (tx_line !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 300);
    chk({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    if (!timed_out) begin
      wait_cyc(CPB / 2);
      st = tx_line;
      for (int i = 0; i < DW; i++) begin
        wait_cyc(CPB);
        b[i] = tx_line;
      end
      wait_cyc(CPB);
      sp = tx_line;
      framing_ok = (st === 1'b0) && (sp === 1'b1);
    end
  endtask

  initial begin
    logic [7:0] rx_b;
    logic       ok;
    int         rv0;
    int         n;

    hif.echo_en_i  = 1'b0;
    hif.rd_en_i    = 1'b0;
    hif.stat_req_i = 1'b0;
    hif.clr_err_i  = 1'b0;

    // Reset state
    wait_cyc(3);
    chk("rst_tx",        tx_line,          1);
    chk("rst_empty",     hif.empty_o,      1);
    chk("rst_full",      hif.full_o,       0);
    chk("rst_count",     hif.count_o,      0);
    chk("rst_data",      hif.data_o,       0);
    chk("rst_overflow",  hif.overflow_o,   0);
    chk("rst_frame_err", hif.frame_err_o,  0);
    chk("rst_busy",      hif.tx_busy_o,    0);
    chk("rst_rx_valid",  hif.rx_valid_o,   0);
    rst = 1'b1;
    wait_cyc(3);

    // 1. Single word, host pop
    rv0 = rv_cnt;
    send_byte(8'hA5, 1'b1);
    chk("t1_rx_valid", rv_cnt - rv0, 1);
    chk("t1_count",    hif.count_o,  1);
    chk("t1_data",     hif.data_o,   8'hA5);
    pulse_pop();
    chk("t1_empty",    hif.empty_o,  1);
    chk("t1_data_emp", hif.data_o,   0);

    // 2. Overfill, clear, drain in order
    for (int w = 1; w <= 5; w++) send_byte(8'(w), 1'b1);
    chk("t2_full",     hif.full_o,     1);
    chk("t2_count",    hif.count_o,    4);
    chk("t2_overflow", hif.overflow_o, 1);
    chk("t2_data",     hif.data_o,     8'h01);
    hif.clr_err_i = 1'b1;
    @(negedge clk);
    hif.clr_err_i = 1'b0;
    chk("t2_clr", hif.overflow_o, 0);
    for (int w = 1; w <= 4; w++) begin
      chk("t2_drain", hif.data_o, 32'(w));
      pulse_pop();
    end
    chk("t2_empty", hif.empty_o, 1);
    pulse_pop();
    chk("t2_pop_empty_cnt", hif.count_o, 0);

    // 3. Echo mode
    hif.echo_en_i = 1'b1;
    fork
      send_byte(8'h3C, 1'b1);
      capture("t3", rx_b, ok);
    join
    chk("t3_byte",    rx_b,         8'h3C);
    chk("t3_framing", ok,           1);
    chk("t3_empty",   hif.empty_o,  1);
    wait_cyc(CPB + 2);
    chk("t3_idle",    hif.tx_busy_o, 0);
    chk("t3_line",    tx_line,       1);
    hif.echo_en_i = 1'b0;
    wait_cyc(2);

    // 4. Status characters
    pulse_stat();
    capture("t4e", rx_b, ok);
    chk("t4_empty_char", rx_b, 8'h65);
    chk("t4_empty_frm",  ok,   1);
    wait_cyc(2 * CPB);
    for (int w = 0; w < 4; w++) send_byte(8'h10 + 8'(w), 1'b1);
    chk("t4_full", hif.full_o, 1);
    pulse_stat();
    capture("t4f", rx_b, ok);
    chk("t4_full_char", rx_b, 8'h66);
    wait_cyc(2 * CPB);
    pulse_pop();
    pulse_pop();
    chk("t4_count2", hif.count_o, 2);
    chk("t4_head",   hif.data_o,  8'h12);
    pulse_stat();
    capture("t4n", rx_b, ok);
    chk("t4_neither_char", rx_b, 8'h6E);
    wait_cyc(2 * CPB);
    pulse_pop();
    pulse_pop();
    chk("t4_drained", hif.empty_o, 1);

    // 5. Framing error and start glitch
    rv0 = rv_cnt;
    send_byte(8'h55, 1'b0);
    wait_cyc(4 * CPB);
    chk("t5_frame_err", hif.frame_err_o, 1);
    chk("t5_count",     hif.count_o,     0);
    chk("t5_no_valid",  rv_cnt - rv0,    0);
    hif.clr_err_i = 1'b1;
    @(negedge clk);
    hif.clr_err_i = 1'b0;
    chk("t5_clr", hif.frame_err_o, 0);
    rx_line = 1'b0;
    @(negedge clk);
    rx_line = 1'b1;
    wait_cyc(20 * CPB);
    chk("t5_glitch_valid", rv_cnt - rv0,    0);
    chk("t5_glitch_count", hif.count_o,     0);
    chk("t5_glitch_ferr",  hif.frame_err_o, 0);

    // 6. Reset mid-frame ('n' = 0x6E, data bit 0 is low)
    send_byte(8'h11, 1'b1);
    chk("t6_pre_count", hif.count_o, 1);
    pulse_stat();
    n = 0;
    while (tx_line !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_start_timeout", {31'd0, (n >= 300)}, 0);
    wait_cyc(CPB + CPB / 2);
    chk("t6_bit0_low", tx_line,       0);
    chk("t6_busy",     hif.tx_busy_o, 1);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_tx",    tx_line,       1);
    chk("t6_rst_count", hif.count_o,   0);
    chk("t6_rst_busy",  hif.tx_busy_o, 0);
    chk("t6_rst_empty", hif.empty_o,   1);
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(3);
    rv0 = rv_cnt;
    send_byte(8'h5A, 1'b1);
    chk("t6_post_valid", rv_cnt - rv0, 1);
    chk("t6_post_count", hif.count_o,  1);
    chk("t6_post_data",  hif.data_o,   8'h5A);
    wait_cyc(4 * CPB);
    chk("t6_no_tx", hif.tx_busy_o, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
